router_mesh_5x5: RTL and testbench

- Self-contained 5x5 2-D mesh network-on-chip used as a closed simulation/benchmark top.
- 25 identical routers with XY dimension-order routing; each node has an on-chip LFSR traffic generator and a checking sink on its local port.
- Only clock and reset are external. Results are exposed as internal status registers, read hierarchically by the bench.

---
 rtl/noc_pkg.sv | 33 +++
 rtl/noc_router_xy.sv | 125 ++++++++++++
 rtl/router_mesh_5x5.sv | 162 ++++++++++++++++
 tb/tb_router_mesh_5x5.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and constants for the 5x5 XY mesh NoC.
// Flit layout, port indices and coordinate helpers.
package noc_pkg;

  localparam int MESH_DIM = 5;
  localparam int NNODE    = MESH_DIM * MESH_DIM;
  localparam int CW       = 3;
  localparam int SEQ_W    = 16;
  localparam int NPORT    = 5;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_S = 3;
  localparam int P_W = 4;

  typedef logic [CW-1:0] coord_t;
  typedef logic [2:0]    pidx_t;

  // [27:25] dst_x [24:22] dst_y [21:19] src_x [18:16] src_y [15:0] seq
  typedef struct packed {
    coord_t             dst_x;
    coord_t             dst_y;
    coord_t             src_x;
    coord_t             src_y;
    logic [SEQ_W-1:0]   seq;
  } flit_t;

  function automatic coord_t mod_dim(input coord_t v);
    return (v >= coord_t'(MESH_DIM)) ? v - coord_t'(MESH_DIM) : v;
  endfunction

endpackage

// File: rtl/noc_router_xy.sv
// Five-port XY router: per-input FIFOs, dimension-order
// route on the FIFO head, per-output round-robin allocation.
module noc_router_xy
  import noc_pkg::*;
#(
  parameter int X     = 0,
  parameter int Y     = 0,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        in_v,
  input  flit_t [NPORT-1:0]       in_f,
  output logic [NPORT-1:0]        in_r,
  output logic [NPORT-1:0]        out_v,
  output flit_t [NPORT-1:0]       out_f,
  input  logic [NPORT-1:0]        out_r,
  output logic                    busy
);

  localparam int     AW = $clog2(DEPTH);
  localparam coord_t XC = coord_t'(X);
  localparam coord_t YC = coord_t'(Y);

  flit_t            mem [NPORT][DEPTH];
  logic [AW-1:0]    rp  [NPORT];
  logic [AW-1:0]    wp  [NPORT];
  logic [AW:0]      cnt [NPORT];
  flit_t            hd  [NPORT];
  pidx_t            dir [NPORT];
  pidx_t            ptr [NPORT];
  pidx_t            gi  [NPORT];
  logic [NPORT-1:0] hv, push, pop, gv, xfer;

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      hd[i]   = mem[i][rp[i]];
      hv[i]   = cnt[i] != '0;
      in_r[i] = cnt[i] != (AW+1)'(DEPTH);
      push[i] = in_v[i] && in_r[i];
    end
  end

  assign busy = |hv;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (push[i]) mem[i][wp[i]] <= in_f[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORT; i++) begin
        rp[i]  <= '0;
        wp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (push[i]) wp[i] <= wp[i] + AW'(1);
        if (pop[i])  rp[i] <= rp[i] + AW'(1);
        cnt[i] <= cnt[i] + {{AW{1'b0}}, push[i]}
                         - {{AW{1'b0}}, pop[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      dir[i] = pidx_t'(P_L);
      unique case (1'b1)
        hd[i].dst_x > XC: dir[i] = pidx_t'(P_E);
        hd[i].dst_x < XC: dir[i] = pidx_t'(P_W);
        (hd[i].dst_x == XC) && (hd[i].dst_y > YC):
          dir[i] = pidx_t'(P_N);
        (hd[i].dst_x == XC) && (hd[i].dst_y < YC):
          dir[i] = pidx_t'(P_S);
        default: dir[i] = pidx_t'(P_L);
      endcase
    end
  end

  // Search starts at ptr; valid never looks at out_r.
  always_comb begin : p_alloc
    int j;
    j = 0;
    for (int o = 0; o < NPORT; o++) begin
      gv[o] = 1'b0;
      gi[o] = '0;
      for (int k = 0; k < NPORT; k++) begin
        j = int'(ptr[o]) + k;
        if (j >= NPORT) j = j - NPORT;
        if (!gv[o] && hv[j] && dir[j] == pidx_t'(o)) begin
          gv[o] = 1'b1;
          gi[o] = pidx_t'(j);
        end
      end
      out_v[o] = gv[o];
      out_f[o] = hd[gi[o]];
      xfer[o]  = gv[o] && out_r[o];
    end
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < NPORT; o++) begin
      if (xfer[o]) pop[gi[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NPORT; o++) ptr[o] <= pidx_t'(P_L);
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (xfer[o]) begin
          ptr[o] <= (gi[o] == pidx_t'(NPORT-1)) ? '0
                                                : gi[o] + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/router_mesh_5x5.sv
// 5x5 XY mesh benchmark top: 25 routers, each node with an
// LFSR traffic generator and a checking sink on its local port.
module router_mesh_5x5
  import noc_pkg::*;
#(
  parameter int               FIFO_DEPTH = 4,
  parameter logic [7:0]       INJ_THRESH = 8'd32,
  parameter logic [15:0]      MAX_PKTS   = 16'd1000,
  parameter logic [15:0]      SEED_BASE  = 16'hACE1,
  parameter logic [NNODE-1:0] INJ_MASK   = '1
) (
  input logic clk,
  input logic reset
);

  logic  [NNODE-1:0][NPORT-1:0] in_v, in_r, out_v, out_r;
  flit_t [NNODE-1:0][NPORT-1:0] in_f, out_f;

  logic [15:0]      sent_cnt [NNODE];
  logic [15:0]      recv_cnt [NNODE];
  logic [NNODE-1:0] err;
  logic [NNODE-1:0] busy;
  logic [31:0]      total_sent;
  logic [31:0]      total_recv;
  logic             any_err;

  for (genvar y = 0; y < MESH_DIM; y++) begin : g_y
    for (genvar x = 0; x < MESH_DIM; x++) begin : g_x
      localparam int          ND   = y * MESH_DIM + x;
      localparam coord_t      XC   = coord_t'(x);
      localparam coord_t      YC   = coord_t'(y);
      localparam coord_t      XN   = coord_t'((x + 1) % MESH_DIM);
      localparam logic [15:0] SEED = SEED_BASE ^ {XC, YC, 10'h155};

      if (y < MESH_DIM - 1) begin : g_n
        assign in_v[ND][P_N]  = out_v[ND+MESH_DIM][P_S];
        assign in_f[ND][P_N]  = out_f[ND+MESH_DIM][P_S];
        assign out_r[ND][P_N] = in_r[ND+MESH_DIM][P_S];
      end else begin : g_n_edge
        assign in_v[ND][P_N]  = 1'b0;
        assign in_f[ND][P_N]  = '0;
        assign out_r[ND][P_N] = 1'b0;
      end

      if (x < MESH_DIM - 1) begin : g_e
        assign in_v[ND][P_E]  = out_v[ND+1][P_W];
        assign in_f[ND][P_E]  = out_f[ND+1][P_W];
        assign out_r[ND][P_E] = in_r[ND+1][P_W];
      end else begin : g_e_edge
        assign in_v[ND][P_E]  = 1'b0;
        assign in_f[ND][P_E]  = '0;
        assign out_r[ND][P_E] = 1'b0;
      end

      if (y > 0) begin : g_s
        assign in_v[ND][P_S]  = out_v[ND-MESH_DIM][P_N];
        assign in_f[ND][P_S]  = out_f[ND-MESH_DIM][P_N];
        assign out_r[ND][P_S] = in_r[ND-MESH_DIM][P_N];
      end else begin : g_s_edge
        assign in_v[ND][P_S]  = 1'b0;
        assign in_f[ND][P_S]  = '0;
        assign out_r[ND][P_S] = 1'b0;
      end

      if (x > 0) begin : g_w
        assign in_v[ND][P_W]  = out_v[ND-1][P_E];
        assign in_f[ND][P_W]  = out_f[ND-1][P_E];
        assign out_r[ND][P_W] = in_r[ND-1][P_E];
      end else begin : g_w_edge
        assign in_v[ND][P_W]  = 1'b0;
        assign in_f[ND][P_W]  = '0;
        assign out_r[ND][P_W] = 1'b0;
      end

      noc_router_xy #(
        .X     (x),
        .Y     (y),
        .DEPTH (FIFO_DEPTH)
      ) u_rtr (
        .clk   (clk),
        .rst_n (reset),
        .in_v  (in_v[ND]),
        .in_f  (in_f[ND]),
        .in_r  (in_r[ND]),
        .out_v (out_v[ND]),
        .out_f (out_f[ND]),
        .out_r (out_r[ND]),
        .busy  (busy[ND])
      );

      logic [15:0] lfsr, sent, recv;
      logic        pend, err_q, fire, acc, rcv;
      flit_t       pf, rf;
      coord_t      rx, dx, dy;

      assign rx   = mod_dim(lfsr[10:8]);
      assign dy   = mod_dim(lfsr[13:11]);
      // Never address ourselves: bump to the next column.
      assign dx   = (rx == XC && dy == YC) ? XN : rx;
      assign fire = INJ_MASK[ND] && !pend && sent < MAX_PKTS
                    && lfsr[7:0] < INJ_THRESH;
      assign acc  = pend && in_r[ND][P_L];
      assign rcv  = out_v[ND][P_L];
      assign rf   = out_f[ND][P_L];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lfsr  <= SEED;
          sent  <= '0;
          recv  <= '0;
          pend  <= 1'b0;
          pf    <= '0;
          err_q <= 1'b0;
        end else begin
          lfsr <= {lfsr[14:0],
                   lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          if (acc) begin
            pend <= 1'b0;
            sent <= sent + 16'd1;
          end else if (fire) begin
            pend     <= 1'b1;
            pf.dst_x <= dx;
            pf.dst_y <= dy;
            pf.src_x <= XC;
            pf.src_y <= YC;
            pf.seq   <= sent;
          end
          if (rcv) begin
            recv <= recv + 16'd1;
            if (rf.dst_x != XC || rf.dst_y != YC ||
                (rf.src_x == XC && rf.src_y == YC))
              err_q <= 1'b1;
          end
        end
      end

      assign in_v[ND][P_L]  = pend;
      assign in_f[ND][P_L]  = pf;
      assign out_r[ND][P_L] = 1'b1;
      assign sent_cnt[ND]   = sent;
      assign recv_cnt[ND]   = recv;
      assign err[ND]        = err_q;
    end
  end

  always_comb begin
    total_sent = '0;
    total_recv = '0;
    for (int n = 0; n < NNODE; n++) begin
      total_sent = total_sent + 32'(sent_cnt[n]);
      total_recv = total_recv + 32'(recv_cnt[n]);
    end
  end

  assign any_err = |err;

  // Status and edge-port signals are observed from outside only.
  logic unused_ok;
  assign unused_ok = ^{total_sent, total_recv, any_err, busy,
                       out_v, out_f, in_r};

endmodule

// File: tb/tb_router_mesh_5x5.sv
// Directed bench for router_mesh_5x5: several mesh instances
// with different traffic settings, checked through status regs.
module tb_router_mesh_5x5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  router_mesh_5x5 #(
    .MAX_PKTS   (16'd0)
  ) u_idle (.clk(clk), .reset(reset));

  // Node (0,0) seed becomes 16'h2400: LFSR[7:0]=0, dst=(4,4).
  router_mesh_5x5 #(
    .INJ_THRESH (8'd1),
    .MAX_PKTS   (16'd1),
    .SEED_BASE  (16'h2555),
    .INJ_MASK   (25'h1)
  ) u_path (.clk(clk), .reset(reset));

  router_mesh_5x5 #(
    .INJ_THRESH (8'd64),
    .MAX_PKTS   (16'd20)
  ) u_drain (.clk(clk), .reset(reset));

  router_mesh_5x5 #(
    .FIFO_DEPTH (2),
    .INJ_THRESH (8'd255),
    .MAX_PKTS   (16'd200)
  ) u_sat (.clk(clk), .reset(reset));

  task automatic apply_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_run++;
    if (u_sat.total_sent !== 32'd0 || u_sat.total_recv !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_totals: sent %0d recv %0d, want 0 0",
               u_sat.total_sent, u_sat.total_recv);
    end
    n_run++;
    if (u_sat.busy !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_fifos: busy %h, want 0", u_sat.busy);
    end
    n_run++;
    if (u_sat.any_err !== 1'b0 || u_drain.any_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: %b %b, want 0 0",
               u_sat.any_err, u_drain.any_err);
    end
    reset = 1'b1;
    @(negedge clk);
    n_run++;
    if (u_sat.total_sent !== 32'd0) begin
      n_fail++;
      $display("FAIL first_edge_sent: got %0d, want 0",
               u_sat.total_sent);
    end
    @(negedge clk);
    // Every seed low byte is 8'hB4: all 25 sat nodes inject.
    n_run++;
    if (u_sat.total_sent !== 32'd25) begin
      n_fail++;
      $display("FAIL second_edge_sat: got %0d, want 25",
               u_sat.total_sent);
    end
    n_run++;
    if (u_drain.total_sent !== 32'd0) begin
      n_fail++;
      $display("FAIL second_edge_drain: got %0d, want 0",
               u_drain.total_sent);
    end
  endtask

  task automatic test_idle();
    int hits;
    hits = 0;
    apply_reset(2);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (|u_idle.out_v) hits++;
    end
    n_run++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL idle_link_valid: %0d cycles, want 0", hits);
    end
    n_run++;
    if (u_idle.total_sent !== 32'd0 || u_idle.total_recv !== 32'd0) begin
      n_fail++;
      $display("FAIL idle_totals: sent %0d recv %0d, want 0 0",
               u_idle.total_sent, u_idle.total_recv);
    end
  endtask

  task automatic test_single_path();
    int t_sent, t_recv;
    t_sent = -1;
    t_recv = -1;
    apply_reset(3);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (t_sent < 0 && u_path.sent_cnt[0] == 16'd1) t_sent = c;
      if (t_recv < 0 && u_path.recv_cnt[24] == 16'd1) t_recv = c;
    end
    n_run++;
    if (t_sent !== 2) begin
      n_fail++;
      $display("FAIL path_inject_cycle: got %0d, want 2", t_sent);
    end
    n_run++;
    if (t_recv - t_sent !== 9) begin
      n_fail++;
      $display("FAIL path_latency: got %0d, want 9", t_recv - t_sent);
    end
    n_run++;
    if (u_path.recv_cnt[24] !== 16'd1 || u_path.total_recv !== 32'd1) begin
      n_fail++;
      $display("FAIL path_recv: node %0d total %0d, want 1 1",
               u_path.recv_cnt[24], u_path.total_recv);
    end
    n_run++;
    if (u_path.err[24] !== 1'b0 || u_path.any_err !== 1'b0) begin
      n_fail++;
      $display("FAIL path_err: %b %b, want 0 0",
               u_path.err[24], u_path.any_err);
    end
  endtask

  task automatic test_drain();
    int cyc, bad;
    cyc = 0;
    bad = 0;
    apply_reset(2);
    while (u_drain.total_recv != 32'd500 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (u_drain.total_recv > u_drain.total_sent) bad++;
    end
    repeat (5) @(negedge clk);
    n_run++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL drain_recv_le_sent: %0d violations, want 0", bad);
    end
    n_run++;
    if (u_drain.total_sent !== 32'd500 || u_drain.total_recv !== 32'd500) begin
      n_fail++;
      $display("FAIL drain_totals: sent %0d recv %0d, want 500 500",
               u_drain.total_sent, u_drain.total_recv);
    end
    for (int n = 0; n < 25; n++) begin
      n_run++;
      if (u_drain.sent_cnt[n] !== 16'd20) begin
        n_fail++;
        $display("FAIL drain_sent_cnt[%0d]: got %0d, want 20",
                 n, u_drain.sent_cnt[n]);
      end
    end
    n_run++;
    if (u_drain.any_err !== 1'b0 || u_drain.busy !== 25'd0) begin
      n_fail++;
      $display("FAIL drain_end_state: err %b busy %h, want 0 0",
               u_drain.any_err, u_drain.busy);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    cyc = 0;
    apply_reset(2);
    while (u_sat.total_recv != 32'd5000 && cyc < 60000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    n_run++;
    if (u_sat.total_recv !== 32'd5000 || u_sat.total_sent !== 32'd5000) begin
      n_fail++;
      $display("FAIL sat_totals: sent %0d recv %0d after %0d cyc, want 5000",
               u_sat.total_sent, u_sat.total_recv, cyc);
    end
    n_run++;
    if (u_sat.any_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_err: got %b, want 0", u_sat.any_err);
    end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] tr_a [300];
    logic [31:0] tr_b [300];
    int diff;
    diff = 0;
    apply_reset(3);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tr_a[c] = u_sat.total_sent;
    end
    n_run++;
    if (u_sat.total_sent == 32'd0) begin
      n_fail++;
      $display("FAIL midrun_load: sent %0d, want nonzero",
               u_sat.total_sent);
    end
    reset = 1'b0;
    #1;
    n_run++;
    if (u_sat.total_sent !== 32'd0 || u_sat.total_recv !== 32'd0 ||
        u_sat.sent_cnt[12] !== 16'd0) begin
      n_fail++;
      $display("FAIL midrun_clear: sent %0d recv %0d node %0d, want 0",
               u_sat.total_sent, u_sat.total_recv, u_sat.sent_cnt[12]);
    end
    n_run++;
    if (u_sat.busy !== 25'd0) begin
      n_fail++;
      $display("FAIL midrun_fifos: busy %h, want 0", u_sat.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      tr_b[c] = u_sat.total_sent;
      if (tr_b[c] !== tr_a[c]) diff++;
    end
    n_run++;
    if (diff !== 0) begin
      n_fail++;
      $display("FAIL midrun_trace: %0d cycles differ, want 0", diff);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_path();
    test_drain();
    test_saturation();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
